// File: rtl/load_cell_a2d_if.sv
// SPI bus between the load_cell_a2d master and the off-chip 8-channel A2D.
interface load_cell_a2d_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/load_cell_a2d.sv
// load_cell_a2d: SPI master front end for an ADC128S-style 8-channel 12-bit A2D.
// Each nxt request runs one round-robin conversion (channels 0, 4, 5, 6):
// a channel-select transaction, a one-clk gap, then a data-read transaction,
// after which the matching result register is written and vld pulses.
// Optional build macro LD_FILT_EN: lft_ld/rght_ld become (old + sample) >> 1.
module load_cell_a2d #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld,
  load_cell_a2d_if.master spi
);

  localparam int DATA_W = 12;
  localparam int Q      = SCLK_DIV / 4;
  localparam int H      = SCLK_DIV / 2;
  localparam int T_LOW  = Q + 16 * SCLK_DIV;
  localparam int CNT_W  = $clog2(T_LOW + 1);
  localparam int PH_W   = $clog2(SCLK_DIV);

  localparam logic [PH_W-1:0]  PH_FALL  = PH_W'(Q);
  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(Q + H);
  localparam logic [CNT_W-1:0] CNT_Q    = CNT_W'(Q);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_LOW);

  typedef enum logic [2:0] {IDLE, CMD, GAP, READ, UPD} state_t;

  state_t state, state_nxt;

  logic              start;
  logic [15:0]       tx_word;
  logic              upd;
  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       shreg;
  logic              ss_n_r;
  logic              sclk_r;
  logic [1:0]        idx;
  logic              in_win;
  logic              sclk_fall;
  logic              sclk_rise;
  logic              done;
  logic [DATA_W-1:0] smp;

  // Round-robin slot to physical A2D channel.
  function automatic logic [2:0] chan_of(input logic [1:0] i);
    case (i)
      2'd0:    chan_of = 3'd0;
      2'd1:    chan_of = 3'd4;
      2'd2:    chan_of = 3'd5;
      default: chan_of = 3'd6;
    endcase
  endfunction

`ifdef LD_FILT_EN
  // First-order filter: average of old value and new sample, 13-bit sum.
  function automatic logic [DATA_W-1:0] ld_avg(input logic [DATA_W-1:0] old_v,
                                               input logic [DATA_W-1:0] s);
    logic [DATA_W:0] sum;
    sum    = {1'b0, old_v} + {1'b0, s};
    ld_avg = sum[DATA_W:1];
  endfunction
`endif

  // cnt holds the number of the clk edge about to occur within the transaction,
  // so SCLK events are decoded straight from cnt (edge 0 is the SS_n fall).
  assign in_win    = busy && (cnt < CNT_LAST);
  assign sclk_fall = in_win && (cnt[PH_W-1:0] == PH_FALL);
  assign sclk_rise = in_win && (cnt[PH_W-1:0] == PH_RISE);
  assign done      = busy && (cnt == CNT_LAST);
  assign smp       = shreg[DATA_W-1:0];

  assign spi.SS_n = ss_n_r;
  assign spi.SCLK = sclk_r;
  assign spi.MOSI = shreg[15];

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sequencer next-state and transaction launch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    tx_word   = 16'h0000;
    upd       = 1'b0;
    case (state)
      IDLE: if (nxt) begin
        start     = 1'b1;
        tx_word   = {2'b00, chan_of(idx), 11'h000};
        state_nxt = CMD;
      end
      CMD:  if (done) state_nxt = GAP;
      GAP: begin
        start     = 1'b1;
        state_nxt = READ;
      end
      READ: if (done) state_nxt = UPD;
      UPD: begin
        upd       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SPI engine: SS_n/SCLK generation, MOSI shift-out and MISO shift-in.
  // The first SCLK fall only starts the clock; MOSI already shows bit 15.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_n_r <= 1'b1;
      sclk_r <= 1'b1;
      busy   <= 1'b0;
      cnt    <= '0;
      shreg  <= 16'h0000;
    end else if (start) begin
      ss_n_r <= 1'b0;
      sclk_r <= 1'b1;
      busy   <= 1'b1;
      cnt    <= CNT_W'(1);
      shreg  <= tx_word;
    end else if (done) begin
      ss_n_r <= 1'b1;
      sclk_r <= 1'b1;
      busy   <= 1'b0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (sclk_fall) begin
        sclk_r <= 1'b0;
        if (cnt != CNT_Q) shreg <= {shreg[14:0], 1'b0};
      end
      if (sclk_rise) begin
        sclk_r   <= 1'b1;
        shreg[0] <= spi.MISO;
      end
    end
  end

  // Result registers, vld pulse and round-robin index.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_ld    <= '0;
      rght_ld   <= '0;
      steer_pot <= '0;
      batt      <= '0;
      vld       <= 1'b0;
      idx       <= 2'd0;
    end else begin
      vld <= upd;
      if (upd) begin
        case (idx)
`ifdef LD_FILT_EN
          2'd0:    lft_ld  <= ld_avg(lft_ld, smp);
          2'd1:    rght_ld <= ld_avg(rght_ld, smp);
`else
          2'd0:    lft_ld  <= smp;
          2'd1:    rght_ld <= smp;
`endif
          2'd2:    steer_pot <= smp;
          default: batt      <= smp;
        endcase
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_load_cell_a2d.sv
// Directed testbench for load_cell_a2d with a behavioural ADC128S-style slave.
module tb_load_cell_a2d;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nxt = 1'b0;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        vld;

  load_cell_a2d_if spi();

  load_cell_a2d #(.SCLK_DIV(32)) dut (
    .clk(clk), .rst(rst), .nxt(nxt),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .vld(vld), .spi(spi)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

`ifdef LD_FILT_EN
  localparam logic [11:0] EXP_SINGLE = 12'h55E;
  localparam logic [11:0] EXP_BUSY   = 12'h333;
  localparam logic [11:0] EXP_RR_L1  = 12'h088;
  localparam logic [11:0] EXP_RR_L   = 12'h2EE;
  localparam logic [11:0] EXP_RR_R   = 12'h111;
`else
  localparam logic [11:0] EXP_SINGLE = 12'hABC;
  localparam logic [11:0] EXP_BUSY   = 12'h666;
  localparam logic [11:0] EXP_RR_L1  = 12'h111;
  localparam logic [11:0] EXP_RR_L   = 12'h555;
  localparam logic [11:0] EXP_RR_R   = 12'h222;
`endif

  // A2D slave model: answers {4'h5, adc_val} MSB first (changing MISO after
  // each SCLK fall), captures MOSI on SCLK rises, and records window timing.
  logic [11:0] adc_val = 12'h000;
  logic [15:0] miso_word = 16'h0000;
  logic [15:0] mosi_sh = 16'h0000;
  logic        ss_prev = 1'b1;
  logic        sclk_prev = 1'b1;
  int          bitn = 15, rises = 0, cyc = 0, hi_cnt = 0;
  int          last_hi = 0, last_low = 0, first_fall = -1, rise_err = 0;
  logic [15:0] mosi_q[$];
  int          rise_q[$];

  always @(negedge clk) begin
    cyc++;
    if (spi.SS_n === 1'b1) hi_cnt++;
    if (ss_prev === 1'b1 && spi.SS_n === 1'b0) begin
      last_hi = hi_cnt; cyc = 0; rises = 0; mosi_sh = 16'h0000;
      bitn = 15; miso_word = {4'h5, adc_val}; first_fall = -1;
    end
    if (sclk_prev === 1'b1 && spi.SCLK === 1'b0 && spi.SS_n === 1'b0) begin
      if (first_fall < 0) first_fall = cyc;
      spi.MISO = miso_word[bitn];
      if (bitn > 0) bitn--;
    end
    if (sclk_prev === 1'b0 && spi.SCLK === 1'b1 && spi.SS_n === 1'b0) begin
      rises++;
      mosi_sh = {mosi_sh[14:0], spi.MOSI};
      if (cyc != 24 + 32 * (rises - 1)) rise_err++;
    end
    if (ss_prev === 1'b0 && spi.SS_n === 1'b1) begin
      last_low = cyc; hi_cnt = 1;
      mosi_q.push_back(mosi_sh);
      rise_q.push_back(rises);
    end
    ss_prev   = spi.SS_n;
    sclk_prev = spi.SCLK;
  end

  // Pulse nxt for one clk and count clk edges (starting with the sampling
  // edge) until vld is seen.
  task automatic convert(output int n, output bit ok);
    ok = 1'b0;
    @(negedge clk); nxt = 1'b1;
    @(posedge clk); #1; nxt = 1'b0; n = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1; n++;
      if (vld) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (spi.SS_n !== 1'b1) begin fails++; $display("FAIL reset_ss_n: got %b want 1", spi.SS_n); end
    tests++; if (spi.SCLK !== 1'b1) begin fails++; $display("FAIL reset_sclk: got %b want 1", spi.SCLK); end
    tests++; if (spi.MOSI !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", spi.MOSI); end
    tests++; if (vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b want 0", vld); end
    tests++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin fails++;
      $display("FAIL reset_results: got %h %h %h %h want 000", lft_ld, rght_ld, steer_pot, batt); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single();
    int n; bit ok; int qb; int re0;
    qb = mosi_q.size(); re0 = rise_err;
    adc_val = 12'hABC;
    convert(n, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_vld_timeout: no vld within budget"); end
    tests++; if (n != 1043) begin fails++; $display("FAIL single_latency: got %0d want 1043", n); end
    tests++; if (lft_ld !== EXP_SINGLE) begin fails++; $display("FAIL single_lft: got %h want %h", lft_ld, EXP_SINGLE); end
    tests++; if ({rght_ld, steer_pot, batt} !== 36'h0) begin fails++;
      $display("FAIL single_others: got %h %h %h want 000", rght_ld, steer_pot, batt); end
    @(posedge clk); #1;
    tests++; if (vld !== 1'b0) begin fails++; $display("FAIL single_vld_width: got %b want 0", vld); end
    tests++; if (mosi_q.size() != qb + 2) begin fails++; $display("FAIL single_txn_count: got %0d want %0d", mosi_q.size() - qb, 2); end
    else begin
      tests++; if (mosi_q[qb] !== 16'h0000) begin fails++; $display("FAIL single_cmd_word: got %h want 0000", mosi_q[qb]); end
      tests++; if (mosi_q[qb+1] !== 16'h0000) begin fails++; $display("FAIL single_read_word: got %h want 0000", mosi_q[qb+1]); end
      tests++; if (rise_q[qb] != 16 || rise_q[qb+1] != 16) begin fails++;
        $display("FAIL single_rises: got %0d/%0d want 16/16", rise_q[qb], rise_q[qb+1]); end
    end
    tests++; if (first_fall != 8) begin fails++; $display("FAIL spi_first_fall: got %0d want 8", first_fall); end
    tests++; if (rise_err != re0) begin fails++; $display("FAIL spi_rise_spacing: got %0d misplaced rises want 0", rise_err - re0); end
    tests++; if (last_low != 520) begin fails++; $display("FAIL spi_ss_low: got %0d want 520", last_low); end
    tests++; if (last_hi != 1) begin fails++; $display("FAIL spi_gap: got %0d want 1", last_hi); end
  endtask

  task automatic test_busy();
    int vcnt; int qb;
    qb = mosi_q.size(); vcnt = 0;
    adc_val = 12'h666;
    @(negedge clk); nxt = 1'b1;
    @(posedge clk); #1; nxt = 1'b0;
    for (int i = 1; i <= 1200; i++) begin
      @(posedge clk); #1;
      if (vld) vcnt++;
      nxt = (i % 37 == 0 && i < 1000) ? 1'b1 : 1'b0;
    end
    nxt = 1'b0;
    tests++; if (vcnt != 1) begin fails++; $display("FAIL busy_vld_count: got %0d want 1", vcnt); end
    tests++; if (rght_ld !== EXP_BUSY) begin fails++; $display("FAIL busy_rght: got %h want %h", rght_ld, EXP_BUSY); end
    tests++; if (lft_ld !== EXP_SINGLE) begin fails++; $display("FAIL busy_lft_hold: got %h want %h", lft_ld, EXP_SINGLE); end
    tests++; if (mosi_q.size() != qb + 2) begin fails++; $display("FAIL busy_txn_count: got %0d want 2", mosi_q.size() - qb); end
    else begin
      tests++; if (mosi_q[qb] !== 16'h2000) begin fails++; $display("FAIL busy_cmd_word: got %h want 2000", mosi_q[qb]); end
    end
  endtask

  task automatic test_reset_mid();
    int vcnt;
    vcnt = 0;
    adc_val = 12'h777;
    @(negedge clk); nxt = 1'b1;
    @(posedge clk); #1; nxt = 1'b0;
    repeat (800) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (spi.SS_n !== 1'b1) begin fails++; $display("FAIL midrst_ss_n: got %b want 1", spi.SS_n); end
    tests++; if (spi.SCLK !== 1'b1) begin fails++; $display("FAIL midrst_sclk: got %b want 1", spi.SCLK); end
    tests++; if (vld !== 1'b0) begin fails++; $display("FAIL midrst_vld: got %b want 0", vld); end
    tests++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin fails++;
      $display("FAIL midrst_results: got %h %h %h %h want 000", lft_ld, rght_ld, steer_pot, batt); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      if (vld) vcnt++;
    end
    tests++; if (vcnt != 0 || steer_pot !== 12'h000) begin fails++;
      $display("FAIL midrst_no_write: got vld count %0d steer %h want 0 000", vcnt, steer_pot); end
  endtask

  task automatic test_round_robin();
    logic [11:0] vals [5];
    logic [15:0] cmds [5];
    int qb; int n; int badr;
    vals = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
    cmds = '{16'h0000, 16'h2000, 16'h2800, 16'h3000, 16'h0000};
    qb = mosi_q.size();
    adc_val = vals[0];
    @(negedge clk); nxt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n = 0;
      for (int i = 0; i < 1100; i++) begin
        @(posedge clk); #1; n++;
        if (vld) break;
      end
      tests++; if (n != 1043) begin fails++; $display("FAIL rr_interval_%0d: got %0d want 1043", c, n); end
      if (c < 4) adc_val = vals[c+1];
      else       nxt = 1'b0;
      if (c == 0) begin
        tests++; if (lft_ld !== EXP_RR_L1) begin fails++; $display("FAIL rr_first_lft: got %h want %h", lft_ld, EXP_RR_L1); end
      end
    end
    nxt = 1'b0;
    tests++; if (lft_ld !== EXP_RR_L) begin fails++; $display("FAIL rr_lft: got %h want %h", lft_ld, EXP_RR_L); end
    tests++; if (rght_ld !== EXP_RR_R) begin fails++; $display("FAIL rr_rght: got %h want %h", rght_ld, EXP_RR_R); end
    tests++; if (steer_pot !== 12'h333) begin fails++; $display("FAIL rr_steer: got %h want 333", steer_pot); end
    tests++; if (batt !== 12'h444) begin fails++; $display("FAIL rr_batt: got %h want 444", batt); end
    tests++; if (mosi_q.size() != qb + 10) begin fails++; $display("FAIL rr_txn_count: got %0d want 10", mosi_q.size() - qb); end
    else begin
      badr = 0;
      for (int c = 0; c < 5; c++) begin
        tests++; if (mosi_q[qb+2*c] !== cmds[c]) begin fails++; $display("FAIL rr_cmd_%0d: got %h want %h", c, mosi_q[qb+2*c], cmds[c]); end
        tests++; if (mosi_q[qb+2*c+1] !== 16'h0000) begin fails++; $display("FAIL rr_read_%0d: got %h want 0000", c, mosi_q[qb+2*c+1]); end
        if (rise_q[qb+2*c] != 16 || rise_q[qb+2*c+1] != 16) badr++;
      end
      tests++; if (badr != 0) begin fails++; $display("FAIL rr_rises: got %0d bad conversions want 0", badr); end
    end
  endtask

`ifdef LD_FILT_EN
  task automatic test_filter();
    int n; bit ok;
    test_reset();
    adc_val = 12'h800;
    convert(n, ok);
    tests++; if (lft_ld !== 12'h400) begin fails++; $display("FAIL filt_lft_1: got %h want 400", lft_ld); end
    convert(n, ok);
    convert(n, ok);
    tests++; if (steer_pot !== 12'h800) begin fails++; $display("FAIL filt_steer: got %h want 800", steer_pot); end
    convert(n, ok);
    convert(n, ok);
    tests++; if (lft_ld !== 12'h600) begin fails++; $display("FAIL filt_lft_2: got %h want 600", lft_ld); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_busy();
    test_reset_mid();
    test_round_robin();
`ifdef LD_FILT_EN
    test_filter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_cell_a2d.md
Name: load_cell_a2d

Overview:
SPI master front end for the off-chip 8-channel 12-bit A2D (ADC128S-style). It is the producer of lft_ld and rght_ld for the steering-enable logic, and of steer_pot and batt for the rest of the segway datapath. On each nxt request it performs one round-robin conversion: a channel-select transaction followed by a data-read transaction. It then updates the matching result register.

Parameters:
SCLK_DIV, 32, clk cycles per SCLK period; must be a power of two, at least 8.

Ports:
clk  input  1  system clock (50MHz)
rst  input  1  synchronous reset, active-high
nxt  input  1  request the next round-robin conversion; sampled only in IDLE
lft_ld  output  12  left load cell, A2D channel 0
rght_ld  output  12  right load cell, A2D channel 4
steer_pot  output  12  steering pot, A2D channel 5
batt  output  12  battery voltage, A2D channel 6
vld  output  1  one-clk pulse when any result register is written
SS_n  output  1  A2D slave select, active low
SCLK  output  1  SPI clock, idles high
MOSI  output  1  SPI data out
MISO  input  1  SPI data in

Behaviour:
- Reset values: all four results = 12'h000, vld = 0, SS_n = 1, SCLK = 1, MOSI = 0, round-robin index = 0, state = IDLE.
- Reset is a synchronous clk edge with rst = 1. It aborts any transaction immediately: SS_n and SCLK go high on that edge, and no result is written.
- Round-robin order is channel 0, 4, 5, 6, then back to 0. The index advances only when a result is written.
- Command word is {2'b00, ch[2:0], 11'h000}, giving 16'h0000, 16'h2000, 16'h2800 and 16'h3000.
- SPI engine, per 16-bit transaction:
  - SS_n falls on clk 0 and the shift register loads the tx word; MOSI = shreg[15].
  - SCLK falls at clk SCLK_DIV/4, then toggles every SCLK_DIV/2 clks.
  - Rising edges occur at SCLK_DIV/4 + SCLK_DIV/2 + k*SCLK_DIV, for k = 0..15.
  - On each SCLK rise, MISO is shifted into shreg[0] (MSB first).
  - On each SCLK fall except the first, shreg shifts left, which presents the next MOSI bit.
  - After the 16th rise SCLK stays high. SS_n rises SCLK_DIV/2 clks after that rise, and an internal done pulses on the same clk.
  - Total SS_n-low time is SCLK_DIV/4 + 16*SCLK_DIV clks (520 at default).
- Sequencing FSM:
  - IDLE: nxt = 1 -> start transaction 1 with the command word; go to CMD.
  - CMD: on done -> GAP.
  - GAP: exactly one clk with SS_n high -> start transaction 2 (tx word 16'h0000); go to READ.
  - READ: on done -> UPD.
  - UPD: write shreg[11:0] to the register selected by the index; pulse vld; advance the index; go to IDLE. shreg[15:12] are ignored.
- Latency: vld asserts 2*(SCLK_DIV/4 + 16*SCLK_DIV) + 3 clks after the clk on which nxt is sampled high in IDLE.
- nxt asserted outside IDLE is ignored, not queued. nxt held high gives back-to-back conversions with 1 idle clk between them.
- Result registers not selected in UPD hold their values. Outputs are registered, with no glitches on SS_n, SCLK or MOSI.

Optional Feature:
LD_FILT_EN.
- When defined, the lft_ld and rght_ld updates become first-order filtered: new_value = (old_value + sample) >> 1, using a 13-bit sum.
- steer_pot and batt remain unfiltered. The first write after reset still averages with 0.
- When undefined, all four registers load the raw sample.
- vld timing is identical in both builds.

Test Plan:
- Reset: assert rst mid-operation -> the next clk shows SS_n = 1, SCLK = 1, all results 0 and vld = 0. The next nxt converts channel 0.
- Single conversion: A2D model returns 12'hABC; pulse nxt -> MOSI words 16'h0000 then 16'h0000. lft_ld = 12'hABC. vld pulses once, 1043 clks after nxt. Other results remain 0.
- Round-robin: 5 nxt pulses with the model returning 12'h111, 222, 333, 444, 555 -> command words 0000, 2000, 2800, 3000, 0000. Final state is lft_ld = 555, rght_ld = 222, steer_pot = 333, batt = 444.
- SPI timing: check SCLK falls at clk 8, rises every 32 clks, and exactly 16 rises per SS_n window. Check SS_n is low for 520 clks and high for exactly 1 clk between CMD and READ.
- Busy handling: pulse nxt repeatedly during CMD/READ -> exactly one vld and one index advance. Assert rst during READ -> no register write and the index returns to 0.
- LD_FILT_EN defined: lft_ld sample 12'h800 twice -> 12'h400, then 12'h600. A steer_pot sample of 12'h800 reads back 12'h800.
